// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: buffers ALU operation requests in a small circular FIFO
// (valid/ready on the input side) and issues them onto registered ALU inputs,
// one issue per ce-enabled cycle.
// Optional feature macro: ALU_SPLIT_ISSUE_EN -- when defined, requests with
// inp_valid=11 are split into an opa beat (01), GAP idle beats (00) and an
// opb beat (10).
module alu_req_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int DEPTH      = 4,
  parameter int GAP        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_opa,
  input  logic [DATA_WIDTH-1:0]   in_opb,
  input  logic                    in_cin,
  input  logic                    in_mode,
  input  logic [CMD_WIDTH-1:0]    in_cmd,
  input  logic [1:0]              in_inp_valid,
  output logic [DATA_WIDTH-1:0]   opa,
  output logic [DATA_WIDTH-1:0]   opb,
  output logic                    cin,
  output logic                    mode,
  output logic [CMD_WIDTH-1:0]    cmd,
  output logic [1:0]              inp_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);

  // Elaboration-time parameter legality
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "alu_req_sequencer: DEPTH must be a power of two >= 2");
  end
  if ((GAP < 0) || (GAP > 14)) begin : g_bad_gap
    $fatal(1, "alu_req_sequencer: GAP must be in 0..14");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic                  cin;
    logic                  mode;
    logic [CMD_WIDTH-1:0]  cmd;
    logic [1:0]            inp_valid;
  } req_t;

`ifdef ALU_SPLIT_ISSUE_EN
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SECOND} state_t;
`else
  typedef enum logic [0:0] {S_IDLE} state_t;
`endif

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  req_t          head;
  req_t          in_req;
  logic          push;
  logic          pop;
  logic          empty;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] opa_next, opb_next;
  logic                  cin_next, mode_next;
  logic [CMD_WIDTH-1:0]  cmd_next;
  logic [1:0]            inp_valid_next;

`ifdef ALU_SPLIT_ISSUE_EN
  logic [3:0]            gap_cnt, gap_next;
  logic [DATA_WIDTH-1:0] pend_opb, pend_opb_next;
`endif

  assign in_req   = '{opa: in_opa, opb: in_opb, cin: in_cin, mode: in_mode,
                      cmd: in_cmd, inp_valid: in_inp_valid};
  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign in_ready = (count < (PW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = !empty || (state != S_IDLE);

  // FIFO storage write (data array needs no reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_req;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state, pop decision and next ALU-side output values
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    opa_next       = opa;
    opb_next       = opb;
    cin_next       = cin;
    mode_next      = mode;
    cmd_next       = cmd;
    inp_valid_next = inp_valid;
`ifdef ALU_SPLIT_ISSUE_EN
    gap_next       = gap_cnt;
    pend_opb_next  = pend_opb;
`endif
    if (ce) begin
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            pop            = 1'b1;
            opa_next       = head.opa;
            opb_next       = head.opb;
            cin_next       = head.cin;
            mode_next      = head.mode;
            cmd_next       = head.cmd;
            inp_valid_next = head.inp_valid;
`ifdef ALU_SPLIT_ISSUE_EN
            if (head.inp_valid == 2'b11) begin
              opb_next       = '0;
              inp_valid_next = 2'b01;
              pend_opb_next  = head.opb;
              gap_next       = 4'(GAP);
              state_next     = (GAP == 0) ? S_SECOND : S_GAP;
            end
`endif
          end else begin
            inp_valid_next = 2'b00;
          end
        end
`ifdef ALU_SPLIT_ISSUE_EN
        S_GAP: begin
          inp_valid_next = 2'b00;
          gap_next       = gap_cnt - 1'b1;
          if (gap_cnt == 4'd1) state_next = S_SECOND;
        end
        S_SECOND: begin
          opb_next       = pend_opb;
          inp_valid_next = 2'b10;
          state_next     = S_IDLE;
        end
`endif
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State register and registered ALU-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      opa       <= '0;
      opb       <= '0;
      cin       <= 1'b0;
      mode      <= 1'b0;
      cmd       <= '0;
      inp_valid <= 2'b00;
`ifdef ALU_SPLIT_ISSUE_EN
      gap_cnt   <= '0;
      pend_opb  <= '0;
`endif
    end else begin
      state     <= state_next;
      opa       <= opa_next;
      opb       <= opb_next;
      cin       <= cin_next;
      mode      <= mode_next;
      cmd       <= cmd_next;
      inp_valid <= inp_valid_next;
`ifdef ALU_SPLIT_ISSUE_EN
      gap_cnt   <= gap_next;
      pend_opb  <= pend_opb_next;
`endif
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed self-checking bench for alu_req_sequencer (DEPTH=4, GAP=2).
module tb_alu_req_sequencer;

  logic       clk = 1'b0;
  logic       rst, ce, in_valid, in_ready;
  logic [7:0] in_opa, in_opb;
  logic       in_cin, in_mode;
  logic [3:0] in_cmd;
  logic [1:0] in_inp_valid;
  logic [7:0] opa, opb;
  logic       cin, mode;
  logic [3:0] cmd;
  logic [1:0] inp_valid;
  logic       busy;
  logic [2:0] count;

  int n_pass  = 0;
  int n_total = 0;

  alu_req_sequencer #(.DATA_WIDTH(8), .CMD_WIDTH(4), .DEPTH(4), .GAP(2)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_cin(in_cin), .in_mode(in_mode),
    .in_cmd(in_cmd), .in_inp_valid(in_inp_valid),
    .opa(opa), .opb(opb), .cin(cin), .mode(mode), .cmd(cmd),
    .inp_valid(inp_valid), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic m, input logic [3:0] k, input logic [1:0] iv);
    in_opa = a; in_opb = b; in_cin = c; in_mode = m; in_cmd = k; in_inp_valid = iv;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0;
    set_req(8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 2'b00);
    tick(); tick();
    n_total++;
    if ({opa, opb, cin, mode, cmd, inp_valid} !== 24'h0) begin
      $display("FAIL reset_outputs: got %h want 000000", {opa, opb, cin, mode, cmd, inp_valid});
    end else n_pass++;
    n_total++;
    if (count !== 3'd0 || busy !== 1'b0) begin
      $display("FAIL reset_count_busy: count=%0d busy=%b want 0/0", count, busy);
    end else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end else n_pass++;
  endtask

  task automatic test_single();
    set_req(8'h12, 8'h34, 1'b0, 1'b1, 4'h0, 2'b11);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (count !== 3'd1 || inp_valid !== 2'b00) begin
      $display("FAIL single_push: count=%0d iv=%b want 1/00", count, inp_valid);
    end else n_pass++;
    tick();
    n_total++;
    if ({inp_valid, opa, opb, mode, cmd} !== {2'b11, 8'h12, 8'h34, 1'b1, 4'h0}) begin
      $display("FAIL single_issue: got iv=%b opa=%h opb=%h mode=%b cmd=%h want 11/12/34/1/0",
               inp_valid, opa, opb, mode, cmd);
    end else n_pass++;
    n_total++;
    if (count !== 3'd0) begin
      $display("FAIL single_count: got %0d want 0", count);
    end else n_pass++;
    tick();
    n_total++;
    if ({inp_valid, opa, busy} !== {2'b00, 8'h12, 1'b0}) begin
      $display("FAIL single_idle: iv=%b opa=%h busy=%b want 00/12/0", inp_valid, opa, busy);
    end else n_pass++;
  endtask

  task automatic test_fill_and_drain();
    logic [7:0] eopa [5];
    logic [7:0] eopb [5];
    logic [3:0] ecmd [5];
    logic [1:0] eiv  [5];
    logic [7:0] held_opa;
    eiv[0] = 2'b01; eiv[1] = 2'b10; eiv[2] = 2'b00; eiv[3] = 2'b01; eiv[4] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      eopa[i] = 8'(8'h10 + i);
      eopb[i] = 8'(8'h20 + i);
      ecmd[i] = 4'(i + 3);
    end
    held_opa = opa;
    ce = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(eopa[i], eopb[i], 1'b0, 1'b0, ecmd[i], eiv[i]);
      #1;
      n_total++;
      if (in_ready !== (i < 4)) begin
        $display("FAIL fill_ready_%0d: got %b want %b", i, in_ready, (i < 4));
      end else n_pass++;
      tick();
    end
    n_total++;
    if ({count, in_ready, busy} !== {3'd4, 1'b0, 1'b1}) begin
      $display("FAIL fill_full: count=%0d ready=%b busy=%b want 4/0/1", count, in_ready, busy);
    end else n_pass++;
    n_total++;
    if ({inp_valid, opa} !== {2'b00, held_opa}) begin
      $display("FAIL fill_hold: iv=%b opa=%h want 00/%h", inp_valid, opa, held_opa);
    end else n_pass++;
    in_valid = 1'b0;
    ce = 1'b1;
    tick();
    n_total++;
    if ({inp_valid, opa, opb, cmd, count} !== {eiv[0], eopa[0], eopb[0], ecmd[0], 3'd3}) begin
      $display("FAIL drain_0: iv=%b opa=%h opb=%h cmd=%h count=%0d want %b/%h/%h/%h/3",
               inp_valid, opa, opb, cmd, count, eiv[0], eopa[0], eopb[0], ecmd[0]);
    end else n_pass++;
    ce = 1'b0;
    tick();
    n_total++;
    if ({inp_valid, opa, count} !== {eiv[0], eopa[0], 3'd3}) begin
      $display("FAIL ce_low_hold: iv=%b opa=%h count=%0d want %b/%h/3",
               inp_valid, opa, count, eiv[0], eopa[0]);
    end else n_pass++;
    ce = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      n_total++;
      if ({inp_valid, opa, opb, cmd, count} !== {eiv[i], eopa[i], eopb[i], ecmd[i], 3'(3 - i)}) begin
        $display("FAIL drain_%0d: iv=%b opa=%h opb=%h cmd=%h count=%0d want %b/%h/%h/%h/%0d",
                 i, inp_valid, opa, opb, cmd, count, eiv[i], eopa[i], eopb[i], ecmd[i], 3 - i);
      end else n_pass++;
    end
    tick();
    n_total++;
    if ({inp_valid, opa, busy} !== {2'b00, eopa[3], 1'b0}) begin
      $display("FAIL drain_done: iv=%b opa=%h busy=%b want 00/%h/0", inp_valid, opa, busy, eopa[3]);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    ce = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(8'(8'h60 + i), 8'h77, 1'b1, 1'b1, 4'h9, 2'b01);
      tick();
    end
    in_valid = 1'b0;
    ce = 1'b1;
    tick();
    n_total++;
    if ({inp_valid, opa, count} !== {2'b01, 8'h60, 3'd2}) begin
      $display("FAIL rstmid_issue: iv=%b opa=%h count=%0d want 01/60/2", inp_valid, opa, count);
    end else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if ({opa, opb, cin, mode, cmd, inp_valid, count, busy} !== 28'h0) begin
      $display("FAIL rstmid_clear: outs=%h count=%0d busy=%b want 0/0/0",
               {opa, opb, cin, mode, cmd, inp_valid}, count, busy);
    end else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({inp_valid, opa, busy} !== {2'b00, 8'h00, 1'b0}) begin
        $display("FAIL rstmid_no_issue_%0d: iv=%b opa=%h busy=%b want 00/00/0", i, inp_valid, opa, busy);
      end else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    ce = 1'b1;
    for (int c = 0; c < 22; c++) begin
      in_valid = (c < 20);
      set_req(8'(8'h40 + c), 8'(8'hC0 + c), 1'b0, 1'b0, 4'(c), 2'b01);
      tick();
      n_total++;
      if (count > 3'd1 || in_ready !== 1'b1) begin
        $display("FAIL stream_count_%0d: count=%0d ready=%b want <=1/1", c, count, in_ready);
      end else n_pass++;
      if (c >= 1 && c <= 20) begin
        n_total++;
        if ({inp_valid, opa, opb} !== {2'b01, 8'(8'h40 + c - 1), 8'(8'hC0 + c - 1)}) begin
          $display("FAIL stream_beat_%0d: iv=%b opa=%h opb=%h want 01/%h/%h",
                   c - 1, inp_valid, opa, opb, 8'(8'h40 + c - 1), 8'(8'hC0 + c - 1));
        end else n_pass++;
      end else if (c == 21) begin
        n_total++;
        if ({inp_valid, busy} !== {2'b00, 1'b0}) begin
          $display("FAIL stream_end: iv=%b busy=%b want 00/0", inp_valid, busy);
        end else n_pass++;
      end
    end
  endtask

`ifdef ALU_SPLIT_ISSUE_EN
  task automatic test_split(input int stall);
    logic [1:0] eiv [4];
    logic [7:0] eopb [4];
    eiv[0] = 2'b01; eiv[1] = 2'b00; eiv[2] = 2'b00; eiv[3] = 2'b10;
    eopb[0] = 8'h00; eopb[1] = 8'h00; eopb[2] = 8'h00; eopb[3] = 8'h5A;
    ce = 1'b1;
    set_req(8'hA5, 8'h5A, 1'b1, 1'b0, 4'h2, 2'b11);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == 2 && stall > 0) begin
        ce = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          n_total++;
          if ({inp_valid, opa, busy} !== {2'b00, 8'hA5, 1'b1}) begin
            $display("FAIL split_stall_%0d: iv=%b opa=%h busy=%b want 00/A5/1", s, inp_valid, opa, busy);
          end else n_pass++;
        end
        ce = 1'b1;
      end
      tick();
      n_total++;
      if ({inp_valid, opa, opb, cmd, cin} !== {eiv[b], 8'hA5, eopb[b], 4'h2, 1'b1}) begin
        $display("FAIL split_beat_%0d: iv=%b opa=%h opb=%h cmd=%h cin=%b want %b/A5/%h/2/1",
                 b, inp_valid, opa, opb, cmd, cin, eiv[b], eopb[b]);
      end else n_pass++;
    end
    tick();
    n_total++;
    if ({inp_valid, busy} !== {2'b00, 1'b0}) begin
      $display("FAIL split_done: iv=%b busy=%b want 00/0", inp_valid, busy);
    end else n_pass++;
  endtask

  task automatic test_split_reset();
    ce = 1'b0;
    in_valid = 1'b1;
    set_req(8'hA5, 8'h5A, 1'b0, 1'b1, 4'h1, 2'b11);
    tick();
    set_req(8'h31, 8'h41, 1'b0, 1'b0, 4'h3, 2'b01);
    tick();
    set_req(8'h32, 8'h42, 1'b0, 1'b0, 4'h3, 2'b01);
    tick();
    in_valid = 1'b0;
    ce = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if ({inp_valid, count, busy} !== {2'b00, 3'd2, 1'b1}) begin
      $display("FAIL splitrst_pre: iv=%b count=%0d busy=%b want 00/2/1", inp_valid, count, busy);
    end else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if ({opa, opb, cin, mode, cmd, inp_valid, count, busy} !== 28'h0) begin
      $display("FAIL splitrst_clear: outs=%h count=%0d busy=%b want 0/0/0",
               {opa, opb, cin, mode, cmd, inp_valid}, count, busy);
    end else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({inp_valid, opa} !== {2'b00, 8'h00}) begin
        $display("FAIL splitrst_no_issue_%0d: iv=%b opa=%h want 00/00", i, inp_valid, opa);
      end else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef ALU_SPLIT_ISSUE_EN
    test_single();
`endif
    test_fill_and_drain();
    test_reset_mid();
    test_back_to_back();
`ifdef ALU_SPLIT_ISSUE_EN
    test_split(0);
    test_split(3);
    test_split_reset();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
